// File: rtl/stack_op_sequencer_if.sv
// Decoder command handshake, status outputs and backing-stack strobes of stack_op_sequencer.
interface stack_op_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  done;
  logic                  err_underflow;
  logic                  err_overflow;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] tos;
  logic [DATA_WIDTH-1:0] nos;
  logic [ADDR_WIDTH+1:0] depth;
  logic                  bs_push;
  logic [DATA_WIDTH-1:0] bs_wdata;
  logic                  bs_pop;
  logic [DATA_WIDTH-1:0] bs_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, bs_rdata,
    output cmd_ready, done, err_underflow, err_overflow, result, tos, nos, depth,
           bs_push, bs_wdata, bs_pop
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, bs_rdata,
    input  cmd_ready, done, err_underflow, err_overflow, result, tos, nos, depth,
           bs_push, bs_wdata, bs_pop
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// Forth data-stack sequencer: TOS/NOS cached in registers, deeper cells spilled to a backing stack.
// Optional macro STACK_SEQ_HWM_EN adds the hwm (max depth since reset) output.
module stack_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  write_clock,
  input  logic                  reset,
  stack_op_sequencer_if.slave   bus
`ifdef STACK_SEQ_HWM_EN
  ,
  output logic [ADDR_WIDTH+1:0] hwm
`endif
);
  localparam int DEPTH_W = ADDR_WIDTH + 2;
  localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'((1 << ADDR_WIDTH) + 2);
  localparam logic [DEPTH_W-1:0] D0 = '0;
  localparam logic [DEPTH_W-1:0] D1 = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] D2 = DEPTH_W'(2);
  localparam logic [DEPTH_W-1:0] D3 = DEPTH_W'(3);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_OVER = 3'd5;
  localparam logic [2:0] OP_ROT  = 3'd6;
  localparam logic [2:0] OP_POP  = 3'd7;

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] tos_q, nos_q, result_q, bs_wdata_q;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  done_q, err_u_q, err_o_q, bs_push_q, bs_pop_q;
  logic                  rot_q, pop_q;

  logic                  accept, grow, shrink, underflow, overflow, needs_fill;
  logic [DEPTH_W-1:0]    req;

  always_comb begin
    accept     = bus.cmd_valid && (state_q == IDLE);
    grow       = (bus.cmd_op == OP_PUSH) || (bus.cmd_op == OP_DUP) || (bus.cmd_op == OP_OVER);
    shrink     = (bus.cmd_op == OP_DROP) || (bus.cmd_op == OP_POP);
    req        = D0;
    case (bus.cmd_op)
      OP_DROP, OP_DUP, OP_POP: req = D1;
      OP_SWAP, OP_OVER:        req = D2;
      OP_ROT:                  req = D3;
      default:                 req = D0;
    endcase
    underflow  = depth_q < req;
    overflow   = grow && (depth_q == DMAX);
    needs_fill = (bus.cmd_op == OP_ROT) || (shrink && (depth_q >= D3));
    depth_d    = depth_q;
    if (accept && !underflow && !overflow && !needs_fill) begin
      if (grow) depth_d = depth_q + D1;
      else if (shrink) depth_d = depth_q - D1;
    end
    // Fill DROP/POP loses its cell when the refill lands; ROT keeps depth.
    if (state_q == FILL_WAIT && !rot_q) depth_d = depth_q - D1;
  end

  always_ff @(posedge write_clock) begin
    if (reset) begin
      state_q    <= IDLE;
      tos_q      <= '0;
      nos_q      <= '0;
      result_q   <= '0;
      bs_wdata_q <= '0;
      depth_q    <= '0;
      done_q     <= 1'b0;
      err_u_q    <= 1'b0;
      err_o_q    <= 1'b0;
      bs_push_q  <= 1'b0;
      bs_pop_q   <= 1'b0;
      rot_q      <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_u_q   <= 1'b0;
      err_o_q   <= 1'b0;
      bs_push_q <= 1'b0;
      bs_pop_q  <= 1'b0;
      depth_q   <= depth_d;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (underflow || overflow) begin
              done_q  <= 1'b1;
              err_u_q <= underflow;
              err_o_q <= overflow;
            end else if (needs_fill) begin
              state_q  <= FILL_REQ;
              bs_pop_q <= 1'b1;
              rot_q    <= (bus.cmd_op == OP_ROT);
              pop_q    <= (bus.cmd_op == OP_POP);
            end else begin
              done_q <= 1'b1;
              // Growing past two cached cells pushes the old NOS out.
              if (grow && depth_q >= D2) begin
                bs_push_q  <= 1'b1;
                bs_wdata_q <= nos_q;
              end
              case (bus.cmd_op)
                OP_PUSH: begin
                  nos_q <= tos_q;
                  tos_q <= bus.cmd_data;
                end
                OP_DUP: nos_q <= tos_q;
                OP_OVER, OP_SWAP: begin
                  nos_q <= tos_q;
                  tos_q <= nos_q;
                end
                OP_DROP, OP_POP: begin
                  if (bus.cmd_op == OP_POP) result_q <= tos_q;
                  tos_q <= (depth_q == D1) ? '0 : nos_q;
                  nos_q <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        FILL_REQ: state_q <= FILL_WAIT;
        FILL_WAIT: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          if (rot_q) begin
            tos_q      <= bus.bs_rdata;
            nos_q      <= tos_q;
            bs_push_q  <= 1'b1;
            bs_wdata_q <= nos_q;
          end else begin
            if (pop_q) result_q <= tos_q;
            tos_q <= nos_q;
            nos_q <= bus.bs_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STACK_SEQ_HWM_EN
  logic [DEPTH_W-1:0] hwm_q;

  always_ff @(posedge write_clock) begin
    if (reset) hwm_q <= '0;
    else if (depth_d > hwm_q) hwm_q <= depth_d;
  end

  assign hwm = hwm_q;
`endif

  assign bus.cmd_ready     = (state_q == IDLE);
  assign bus.done          = done_q;
  assign bus.err_underflow = err_u_q;
  assign bus.err_overflow  = err_o_q;
  assign bus.result        = result_q;
  assign bus.tos           = tos_q;
  assign bus.nos           = nos_q;
  assign bus.depth         = depth_q;
  assign bus.bs_push       = bs_push_q;
  assign bus.bs_wdata      = bs_wdata_q;
  assign bus.bs_pop        = bs_pop_q;
endmodule
